// File: rtl/mul_accumulator.sv
// Accumulates a frame of signed/unsigned multiplier products into a widened sum
// and presents the frame result (sum, beat count, overflow, mode error) on a valid/ready port.
module mul_accumulator #(
  parameter int n     = 8,
  parameter int g     = 8,
  parameter int cnt_w = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [2*n-1:0]       product,
  input  logic                 signed_mul,
  input  logic                 last,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [2*n+g-1:0]     acc,
  output logic [cnt_w-1:0]     count,
  output logic                 overflow,
  output logic                 mode_err
);

  localparam int acc_w = 2*n + g;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [acc_w-1:0]   r_acc;
  logic [cnt_w-1:0]   r_count;
  logic               r_ovf;
  logic               r_merr;
  logic               r_mode;

  logic               w_accept;
  logic               w_take;
  logic               w_mode;
  logic [acc_w-1:0]   w_ext;
  logic [acc_w:0]     w_sum;
  logic               w_ovf;

  // Handshake outputs decode only the state register, so up_valid never reaches up_ready.
  assign up_ready   = (r_state != S_DONE);
  assign down_valid = (r_state == S_DONE);
  assign w_accept   = up_valid && up_ready;
  assign w_take     = down_valid && down_ready;

  // The first beat of a frame defines the mode; later beats reuse the latched one.
  assign w_mode = (r_state == S_IDLE) ? signed_mul : r_mode;
  assign w_ext  = {{g{w_mode & product[2*n-1]}}, product};
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_ext};
  assign w_ovf  = r_mode ? ((r_acc[acc_w-1] == w_ext[acc_w-1]) &&
                            (w_sum[acc_w-1] != r_acc[acc_w-1]))
                         : w_sum[acc_w];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: w_next gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = last ? S_DONE : S_ACCUM;
      S_ACCUM: if (w_accept && last) w_next = S_DONE;
      S_DONE:  if (w_take) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_merr  <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode  <= signed_mul;
            r_acc   <= w_ext;
            r_count <= cnt_w'(1);
            r_ovf   <= 1'b0;
            r_merr  <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum[acc_w-1:0];
            if (r_count != '1)          r_count <= r_count + 1'b1;
            if (w_ovf)                  r_ovf   <= 1'b1;
            if (signed_mul != r_mode)   r_merr  <= 1'b1;
          end
        end
        S_DONE: begin
          if (w_take) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_merr  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign acc      = r_acc;
  assign count    = r_count;
  assign overflow = r_ovf;
  assign mode_err = r_merr;

endmodule

// File: tb/tb_mul_accumulator.sv
// Scoreboard bench for mul_accumulator: instance A (n=4, g=8) and instance B (n=4, g=1)
// share beat data but have independent valid/ready handshakes.
module tb_mul_accumulator;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int AW_A = 16;
  localparam int AW_B = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2*N-1:0] product    = '0;
  logic           signed_mul = 1'b0;
  logic           last       = 1'b0;

  logic            a_up_valid = 1'b0, a_down_ready = 1'b0;
  logic            a_up_ready, a_down_valid, a_overflow, a_mode_err;
  logic [AW_A-1:0] a_acc;
  logic [CW-1:0]   a_count;

  logic            b_up_valid = 1'b0, b_down_ready = 1'b0;
  logic            b_up_ready, b_down_valid, b_overflow, b_mode_err;
  logic [AW_B-1:0] b_acc;
  logic [CW-1:0]   b_count;

  mul_accumulator #(.n(N), .g(8), .cnt_w(CW)) u_a (
    .clk(clk), .rst(rst),
    .up_valid(a_up_valid), .up_ready(a_up_ready),
    .product(product), .signed_mul(signed_mul), .last(last),
    .down_valid(a_down_valid), .down_ready(a_down_ready),
    .acc(a_acc), .count(a_count), .overflow(a_overflow), .mode_err(a_mode_err)
  );

  mul_accumulator #(.n(N), .g(1), .cnt_w(CW)) u_b (
    .clk(clk), .rst(rst),
    .up_valid(b_up_valid), .up_ready(b_up_ready),
    .product(product), .signed_mul(signed_mul), .last(last),
    .down_valid(b_down_valid), .down_ready(b_down_ready),
    .acc(b_acc), .count(b_count), .overflow(b_overflow), .mode_err(b_mode_err)
  );

  typedef struct {
    logic [15:0] acc;
    logic [7:0]  count;
    logic        ovf;
    logic        merr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit sel, input logic [15:0] acc_e, input logic [7:0] cnt_e,
                      input logic ovf_e, input logic merr_e);
    exp_t e;
    e.acc = acc_e; e.count = cnt_e; e.ovf = ovf_e; e.merr = merr_e;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Monitors: pop the next expected frame whenever a result handshake occurs.
  always @(negedge clk) begin
    if (rst && a_down_valid && a_down_ready) begin
      if (q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_result: got acc=%0h expected no result", a_acc);
      end else begin
        ea = q_a.pop_front();
        check("a_acc",      32'(a_acc),      32'(ea.acc));
        check("a_count",    32'(a_count),    32'(ea.count));
        check("a_overflow", 32'(a_overflow), 32'(ea.ovf));
        check("a_mode_err", 32'(a_mode_err), 32'(ea.merr));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && b_down_valid && b_down_ready) begin
      if (q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_result: got acc=%0h expected no result", b_acc);
      end else begin
        eb = q_b.pop_front();
        check("b_acc",      32'(b_acc),      32'(eb.acc));
        check("b_count",    32'(b_count),    32'(eb.count));
        check("b_overflow", 32'(b_overflow), 32'(eb.ovf));
        check("b_mode_err", 32'(b_mode_err), 32'(eb.merr));
      end
    end
  end

  task automatic beat(input bit sel, input logic [7:0] p, input logic s, input logic l);
    int t;
    product = p; signed_mul = s; last = l;
    if (sel) b_up_valid = 1'b1;
    else     a_up_valid = 1'b1;
    t = 0;
    while (!(sel ? b_up_ready : a_up_ready) && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL beat_timeout: up_ready stayed 0, expected 1 within 20 cycles");
    end
    @(posedge clk); #1;
    a_up_valid = 1'b0; b_up_valid = 1'b0; last = 1'b0;
    if (l) check("down_valid_latency", 32'(sel ? b_down_valid : a_down_valid), 32'd1);
  endtask

  task automatic take(input bit sel);
    int t;
    if (sel) b_down_ready = 1'b1;
    else     a_down_ready = 1'b1;
    t = 0;
    while (!(sel ? b_down_valid : a_down_valid) && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL take_timeout: down_valid stayed 0, expected 1 within 20 cycles");
    end
    @(posedge clk); #1;
    a_down_ready = 1'b0; b_down_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc",        32'(a_acc),        32'd0);
    check("rst_count",      32'(a_count),      32'd0);
    check("rst_overflow",   32'(a_overflow),   32'd0);
    check("rst_mode_err",   32'(a_mode_err),   32'd0);
    check("rst_down_valid", 32'(a_down_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_up_ready",   32'(a_up_ready),   32'd1);

    // Unsigned frame: 225 + 225 = 450
    push(0, 16'h01C2, 8'd2, 1'b0, 1'b0);
    beat(0, 8'd225, 1'b0, 1'b0);
    beat(0, 8'd225, 1'b0, 1'b1);
    take(0);

    // Signed: -15 + 16 = 1
    push(0, 16'h0001, 8'd2, 1'b0, 1'b0);
    beat(0, 8'hF1, 1'b1, 1'b0);
    beat(0, 8'h10, 1'b1, 1'b1);
    take(0);

    // Unsigned: 241 + 16 = 257
    push(0, 16'h0101, 8'd2, 1'b0, 1'b0);
    beat(0, 8'hF1, 1'b0, 1'b0);
    beat(0, 8'h10, 1'b0, 1'b1);
    take(0);

    // Mode mismatch: -1 (signed) + 1 extended as signed = 0
    push(0, 16'h0000, 8'd2, 1'b0, 1'b1);
    beat(0, 8'hFF, 1'b1, 1'b0);
    beat(0, 8'h01, 1'b0, 1'b1);
    take(0);

    // Backpressure with idle cycles inside the frame: 0x12 + 0x34 = 0x46
    push(0, 16'h0046, 8'd2, 1'b0, 1'b0);
    beat(0, 8'h12, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    beat(0, 8'h34, 1'b0, 1'b1);
    product = 8'h55; signed_mul = 1'b0; last = 1'b1; a_up_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_up_ready",   32'(a_up_ready),   32'd0);
      check("bp_down_valid", 32'(a_down_valid), 32'd1);
      check("bp_acc",        32'(a_acc),        32'h46);
      check("bp_count",      32'(a_count),      32'd2);
    end
    a_up_valid = 1'b0; last = 1'b0;
    take(0);
    check("idle_down_valid", 32'(a_down_valid), 32'd0);
    check("idle_up_ready",   32'(a_up_ready),   32'd1);
    check("idle_acc",        32'(a_acc),        32'd0);
    check("idle_count",      32'(a_count),      32'd0);
    push(0, 16'h0055, 8'd1, 1'b0, 1'b0);
    beat(0, 8'h55, 1'b0, 1'b1);
    take(0);

    // Reset mid-frame discards partial data
    beat(0, 8'h03, 1'b0, 1'b0);
    beat(0, 8'h04, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_acc",        32'(a_acc),        32'd0);
    check("midrst_count",      32'(a_count),      32'd0);
    check("midrst_overflow",   32'(a_overflow),   32'd0);
    check("midrst_mode_err",   32'(a_mode_err),   32'd0);
    check("midrst_down_valid", 32'(a_down_valid), 32'd0);
    rst = 1'b1;
    push(0, 16'h0007, 8'd1, 1'b0, 1'b0);
    beat(0, 8'h07, 1'b0, 1'b1);
    take(0);

    // Unsigned overflow in 9 bits: 675 mod 512 = 163
    push(1, 16'd163, 8'd3, 1'b1, 1'b0);
    beat(1, 8'd225, 1'b0, 1'b0);
    beat(1, 8'd225, 1'b0, 1'b0);
    beat(1, 8'd225, 1'b0, 1'b1);
    take(1);

    // Signed overflow in 9 bits: 127*3 = 381 = 9'h17D, positive operands yield negative sum
    push(1, 16'h017D, 8'd3, 1'b1, 1'b0);
    beat(1, 8'h7F, 1'b1, 1'b0);
    beat(1, 8'h7F, 1'b1, 1'b0);
    beat(1, 8'h7F, 1'b1, 1'b1);
    take(1);

    repeat (2) @(posedge clk);
    #1;
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
